// File: rtl/epi_noc_pkg.sv
// Shared constants and types for the epidemic-routing NoC node schedulers.
package epi_noc_pkg;

    localparam int EPI_DW = 8;

    localparam int PORT_L     = 0;
    localparam int PORT_R     = 1;
    localparam int PORT_T     = 2;
    localparam int PORT_B     = 3;
    localparam int PORT_LOCAL = 4;

    typedef enum logic {
        IDLE,
        HOLD
    } arb_state_t;

endpackage

// File: rtl/epi_rr_pick.sv
// Rotating priority encoder: returns the first set request at or after ptr, wrapping mod N.
module epi_rr_pick #(
    parameter int N = 5,
    localparam int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [IW-1:0] idx,
    output logic          any
);

    function automatic logic [IW-1:0] wrap_add(input logic [IW-1:0] p, input int off);
        int s;
        s = int'(p) + off;
        if (s >= N) s = s - N;
        return IW'(s);
    endfunction

    // Scan from the farthest offset down so the nearest requester to ptr is the last one written.
    always_comb begin
        idx = '0;
        any = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            if (req[wrap_add(ptr, i)]) begin
                idx = wrap_add(ptr, i);
                any = 1'b1;
            end
        end
    end

endmodule

// File: rtl/epi_out_arb.sv
// Round-robin output-link arbiter with bounded bursts and a registered output stage.
// Optional macro EPI_ARB_LOCAL_PRIO_EN: the local requester wins arbitration whenever valid.
module epi_out_arb
    import epi_noc_pkg::*;
#(
    parameter int N_REQ    = 5,
    parameter int DW       = EPI_DW,
    parameter int HOLD_MAX = 4,
    localparam int SW = $clog2(N_REQ)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [N_REQ-1:0]    req_valid,
    input  logic [N_REQ*DW-1:0] req_data,
    output logic [N_REQ-1:0]    req_ready,
    output logic                o_valid,
    output logic [DW-1:0]       o_data,
    output logic [SW-1:0]       o_src,
    input  logic                o_ready,
    output logic                busy
);

    arb_state_t    state;
    logic [SW-1:0] owner;
    logic [SW-1:0] ptr;
    logic [SW-1:0] rr_idx;
    logic [SW-1:0] pick;
    logic [SW-1:0] ptr_next;
    logic          rr_any;
    logic [7:0]    cnt;
    logic          out_free;
    logic          owner_valid;
    logic          xfer;
    logic          burst_done;
    logic [DW-1:0] data_arr [N_REQ];

    for (genvar g = 0; g < N_REQ; g++) begin : g_unpack
        assign data_arr[g] = req_data[g*DW +: DW];
    end

    epi_rr_pick #(.N(N_REQ)) u_pick (
        .req (req_valid),
        .ptr (ptr),
        .idx (rr_idx),
        .any (rr_any)
    );

`ifdef EPI_ARB_LOCAL_PRIO_EN
    assign pick = req_valid[N_REQ-1] ? SW'(N_REQ - 1) : rr_idx;
`else
    assign pick = rr_idx;
`endif

    assign out_free    = !o_valid | o_ready;
    assign owner_valid = req_valid[owner];
    assign xfer        = (state == HOLD) & owner_valid & out_free;
    assign burst_done  = xfer & (cnt == 8'(HOLD_MAX - 1));
    assign ptr_next    = (owner == SW'(N_REQ - 1)) ? '0 : owner + 1'b1;
    assign busy        = (state == HOLD);

    // Ready depends only on registered state and the output handshake, never on req_valid.
    always_comb begin
        req_ready = '0;
        if (state == HOLD && out_free) req_ready[owner] = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            owner   <= '0;
            ptr     <= '0;
            cnt     <= '0;
            o_valid <= 1'b0;
            o_data  <= '0;
            o_src   <= '0;
        end else begin
            if (xfer) begin
                o_valid <= 1'b1;
                o_data  <= data_arr[owner];
                o_src   <= owner;
            end else if (o_valid && o_ready) begin
                o_valid <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (rr_any) begin
                        owner <= pick;
                        cnt   <= '0;
                        state <= HOLD;
                    end
                end
                HOLD: begin
                    if (xfer) cnt <= cnt + 8'd1;
                    if (!owner_valid || burst_done) begin
                        state <= IDLE;
                        ptr   <= ptr_next;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_epi_out_arb.sv
// Directed self-checking bench for epi_out_arb: one instance with HOLD_MAX=4, one with HOLD_MAX=2.
module tb_epi_out_arb;

    localparam int N  = 5;
    localparam int DW = 8;
    localparam int SW = 3;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    a_valid, a_ready, b_valid, b_ready;
    logic [N*DW-1:0] a_data, b_data;
    logic            a_ovalid, b_ovalid, a_oready, b_oready, a_busy, b_busy;
    logic [DW-1:0]   a_odata, b_odata;
    logic [SW-1:0]   a_osrc, b_osrc;
    logic            exp_valid;
    int              exp_src;
    int              pass_cnt = 0;
    int              total_cnt = 0;

    always #5 clk = ~clk;

    epi_out_arb #(.N_REQ(N), .DW(DW), .HOLD_MAX(4)) u_a (
        .clk       (clk),
        .rst       (rst),
        .req_valid (a_valid),
        .req_data  (a_data),
        .req_ready (a_ready),
        .o_valid   (a_ovalid),
        .o_data    (a_odata),
        .o_src     (a_osrc),
        .o_ready   (a_oready),
        .busy      (a_busy)
    );

    epi_out_arb #(.N_REQ(N), .DW(DW), .HOLD_MAX(2)) u_b (
        .clk       (clk),
        .rst       (rst),
        .req_valid (b_valid),
        .req_data  (b_data),
        .req_ready (b_ready),
        .o_valid   (b_ovalid),
        .o_data    (b_odata),
        .o_src     (b_osrc),
        .o_ready   (b_oready),
        .busy      (b_busy)
    );

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_a(input int k, input logic [DW-1:0] v);
        a_data[k*DW +: DW] = v;
    endtask

    initial begin
        rst      = 1'b1;
        a_valid  = '0;
        b_valid  = '0;
        a_data   = '0;
        b_data   = '0;
        a_oready = 1'b1;
        b_oready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_output("rst_o_valid", 32'(a_ovalid), 'h0);
        check_output("rst_o_data", 32'(a_odata), 'h0);
        check_output("rst_o_src", 32'(a_osrc), 'h0);
        check_output("rst_req_ready", 32'(a_ready), 'h0);
        check_output("rst_busy", 32'(a_busy), 'h0);
        check_output("rst_ptr", 32'(u_a.ptr), 'h0);
        #2 rst = 1'b0;
        step();

        // Single requester: 0x11, 0x22, 0x33 from requester 2
        a_valid = 5'b00100;
        set_a(2, 8'h11);
        step();
        check_output("single_grant_ready", 32'(a_ready), 'h04);
        check_output("single_busy", 32'(a_busy), 'h1);
        check_output("single_bubble_o_valid", 32'(a_ovalid), 'h0);
        step();
        check_output("single_o_valid", 32'(a_ovalid), 'h1);
        check_output("single_d0", 32'(a_odata), 'h11);
        check_output("single_src0", 32'(a_osrc), 'h2);
        set_a(2, 8'h22);
        step();
        check_output("single_d1", 32'(a_odata), 'h22);
        set_a(2, 8'h33);
        step();
        check_output("single_d2", 32'(a_odata), 'h33);
        check_output("single_src2", 32'(a_osrc), 'h2);
        a_valid = '0;
        step();
        check_output("single_exit_busy", 32'(a_busy), 'h0);
        check_output("single_exit_ptr", 32'(u_a.ptr), 'h3);
        check_output("single_drain", 32'(a_ovalid), 'h0);

        // Pointer wrap: owner 3 exits, then 4 beats 0, then ptr wraps to 0
        a_valid = 5'b01000;
        set_a(3, 8'h44);
        step();
        check_output("wrap_grant3", 32'(a_ready), 'h08);
        step();
        a_valid = '0;
        step();
        check_output("wrap_ptr4", 32'(u_a.ptr), 'h4);
        a_valid = 5'b10001;
        set_a(4, 8'h55);
        set_a(0, 8'h66);
        step();
        check_output("wrap_grant4", 32'(a_ready), 'h10);
        step();
        check_output("wrap_src4", 32'(a_osrc), 'h4);
        check_output("wrap_d4", 32'(a_odata), 'h55);
        a_valid = 5'b00001;
        step();
        check_output("wrap_ptr0", 32'(u_a.ptr), 'h0);
        check_output("wrap_idle", 32'(a_busy), 'h0);
        step();
        check_output("wrap_grant0", 32'(a_ready), 'h01);
        step();
        check_output("wrap_src0", 32'(a_osrc), 'h0);
        check_output("wrap_d0", 32'(a_odata), 'h66);
        a_valid = '0;
        step();

        // Backpressure mid-burst on requester 1
        a_valid = 5'b00010;
        set_a(1, 8'hA1);
        step();
        step();
        check_output("bp_d1", 32'(a_odata), 'hA1);
        a_oready = 1'b0;
        set_a(1, 8'hA2);
        for (int i = 0; i < 5; i++) begin
            step();
            check_output("bp_o_valid", 32'(a_ovalid), 'h1);
            check_output("bp_o_data", 32'(a_odata), 'hA1);
            check_output("bp_req_ready", 32'(a_ready), 'h0);
            check_output("bp_cnt", 32'(u_a.cnt), 'h1);
        end
        a_oready = 1'b1;
        step();
        check_output("bp_d2", 32'(a_odata), 'hA2);
        set_a(1, 8'hA3);
        step();
        check_output("bp_d3", 32'(a_odata), 'hA3);
        check_output("bp_cnt3", 32'(u_a.cnt), 'h3);
        set_a(1, 8'hA4);
        step();
        check_output("bp_d4", 32'(a_odata), 'hA4);
        check_output("bp_limit_busy", 32'(a_busy), 'h0);
        check_output("bp_limit_ptr", 32'(u_a.ptr), 'h2);
        a_valid = '0;
        step();
        check_output("bp_drain", 32'(a_ovalid), 'h0);

        // Asynchronous reset mid-burst
        a_valid = 5'b00010;
        set_a(1, 8'hB1);
        step();
        step();
        check_output("mrst_pre_valid", 32'(a_ovalid), 'h1);
        a_oready = 1'b0;
        #2 rst = 1'b1;
        #1;
        check_output("mrst_o_valid", 32'(a_ovalid), 'h0);
        check_output("mrst_o_data", 32'(a_odata), 'h0);
        check_output("mrst_o_src", 32'(a_osrc), 'h0);
        check_output("mrst_req_ready", 32'(a_ready), 'h0);
        check_output("mrst_busy", 32'(a_busy), 'h0);
        #2 rst = 1'b0;
        a_valid  = 5'b01010;
        a_oready = 1'b1;
        step();
        check_output("mrst_first_grant", 32'(a_ready), 'h02);
        a_valid = '0;
        step();
        step();

        // Local priority: ptr=0, requesters 1 and 4 valid
        b_valid = 5'b10010;
        step();
`ifdef EPI_ARB_LOCAL_PRIO_EN
        check_output("prio_grant", 32'(b_ready), 'h10);
`else
        check_output("prio_grant", 32'(b_ready), 'h02);
`endif
        b_valid = '0;
        step();
        step();

        // All requesters valid with HOLD_MAX=2
        #2 rst = 1'b1;
        #2 rst = 1'b0;
        b_valid = 5'b11111;
        for (int k = 0; k < N; k++) b_data[k*DW +: DW] = 8'(8'h40 + k);
        for (int k = 1; k <= 18; k++) begin
            step();
            exp_valid = (k >= 2) && (((k - 2) % 3) < 2);
            exp_src   = ((k - 2) / 3) % 5;
            check_output("all_o_valid", 32'(b_ovalid), 32'(exp_valid));
            if (exp_valid) begin
                check_output("all_o_src", 32'(b_osrc), 32'(exp_src));
                check_output("all_o_data", 32'(b_odata), 32'('h40 + exp_src));
            end
        end
        b_valid = '0;
        step();

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
